// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter sharing one single-port data memory between NUM_REQ
//   requesters. One read or write transaction is in flight at a time.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   req          per-requester request, held high until gnt
//   req_we       per-requester write flag (1 = write, 0 = read)
//   req_addr     packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata    packed write data, same packing
//   gnt          one-hot grant pulse, asserted in the issue cycle
//   rsp_valid    one-hot read-response pulse
//   rsp_rdata    read data, held until the next read response
//   mem_we       memory write enable (issue cycle only)
//   mem_addr     memory address
//   mem_wdata    memory write data
//   mem_rdata    memory read data, valid READ_LAT cycles after issue
//   busy         high whenever a transaction is in progress
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win;
  logic             cap_we;
  logic [1:0]       cnt;

  logic             any_req;
  logic [IDX_W-1:0] win_c;
  logic             cnt_last;

  // Rotating priority search: first set request starting at rr_ptr.
  always_comb begin
    int unsigned pos;
    any_req = 1'b0;
    win_c   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(rr_ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!any_req && req[IDX_W'(pos)]) begin
        any_req = 1'b1;
        win_c   = IDX_W'(pos);
      end
    end
  end

  assign cnt_last = (cnt == 2'(READ_LAT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    gnt       = '0;
    rsp_valid = '0;
    mem_we    = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (any_req) state_n = ISSUE;
      ISSUE: begin
        gnt[win] = 1'b1;
        mem_we   = cap_we;
        state_n  = cap_we ? IDLE : WAIT;
      end
      WAIT:  if (cnt_last) state_n = RESP;
      RESP: begin
        rsp_valid[win] = 1'b1;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Captured address/data drive the memory pins directly, so they hold their
  // last value everywhere except across the capture edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      win       <= '0;
      cap_we    <= 1'b0;
      cnt       <= '0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (any_req) begin
            win       <= win_c;
            cap_we    <= req_we[win_c];
            mem_addr  <= req_addr[win_c*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[win_c*DATA_W +: DATA_W];
          end
        end
        ISSUE: begin
          if (win == IDX_W'(NUM_REQ - 1)) rr_ptr <= '0;
          else                            rr_ptr <= win + 1'b1;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt_last) rsp_rdata <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // DUT A: READ_LAT=1
  logic [2:0]  req_a = '0, we_a = '0;
  logic [11:0] addr_a = '0, wd_a = '0;
  logic [2:0]  gnt_a, rv_a;
  logic [3:0]  rdata_a, maddr_a, mwd_a, mrd_a;
  logic        mwe_a, busy_a;

  // DUT B: READ_LAT=3
  logic [2:0]  req_b = '0, we_b = '0;
  logic [11:0] addr_b = '0, wd_b = '0;
  logic [2:0]  gnt_b, rv_b;
  logic [3:0]  rdata_b, maddr_b, mwd_b, mrd_b;
  logic        mwe_b, busy_b;

  mem_port_arbiter #(.NUM_REQ(3), .ADDR_W(4), .DATA_W(4), .READ_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .req_we(we_a), .req_addr(addr_a),
    .req_wdata(wd_a), .gnt(gnt_a), .rsp_valid(rv_a), .rsp_rdata(rdata_a),
    .mem_we(mwe_a), .mem_addr(maddr_a), .mem_wdata(mwd_a), .mem_rdata(mrd_a),
    .busy(busy_a));

  mem_port_arbiter #(.NUM_REQ(3), .ADDR_W(4), .DATA_W(4), .READ_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_we(we_b), .req_addr(addr_b),
    .req_wdata(wd_b), .gnt(gnt_b), .rsp_valid(rv_b), .rsp_rdata(rdata_b),
    .mem_we(mwe_b), .mem_addr(maddr_b), .mem_wdata(mwd_b), .mem_rdata(mrd_b),
    .busy(busy_b));

  // Memory models: synchronous write, read pipelined by the latency.
  logic [3:0] mem_a [16];
  logic [3:0] mem_b [16];
  logic [3:0] pipe_a;
  logic [3:0] pipe_b [3];
  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_b[5] = 4'h7;
  end
  always @(posedge clk) begin
    if (mwe_a) mem_a[maddr_a] <= mwd_a;
    if (mwe_b) mem_b[maddr_b] <= mwd_b;
    pipe_a    <= mem_a[maddr_a];
    pipe_b[0] <= mem_b[maddr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign mrd_a = pipe_a;
  assign mrd_b = pipe_b[2];

  typedef struct {
    int         dut;
    logic       rsp;
    int         idx;
    logic       we;
    logic [3:0] addr;
    logic [3:0] wdata;
    logic [3:0] rdata;
    int         at;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic exp_gnt(input int d, input int idx, input logic we,
                         input logic [3:0] a, input logic [3:0] wd, input int at);
    exp_t e;
    e.dut = d; e.rsp = 1'b0; e.idx = idx; e.we = we; e.addr = a;
    e.wdata = wd; e.rdata = '0; e.at = at;
    q.push_back(e);
  endtask

  task automatic exp_rsp(input int d, input int idx, input logic [3:0] rd, input int at);
    exp_t e;
    e.dut = d; e.rsp = 1'b1; e.idx = idx; e.we = 1'b0; e.addr = '0;
    e.wdata = '0; e.rdata = rd; e.at = at;
    q.push_back(e);
  endtask

  task automatic mon(input int d, input logic [2:0] g, input logic [2:0] rv,
                     input logic we, input logic [3:0] a, input logic [3:0] wd,
                     input logic [3:0] rd);
    exp_t e;
    chk($sformatf("dut%0d_we_outside_gnt", d), {63'd0, we && (g == 3'b000)}, 64'd0);
    if (g != 3'b000 || rv != 3'b000) begin
      if (q.size() == 0) begin
        chk($sformatf("dut%0d_unexpected_event gnt/rsp", d), {58'd0, g, rv}, 64'd0);
      end else begin
        e = q.pop_front();
        chk($sformatf("dut%0d_event_kind", d), {62'd0, e.dut[0], rv != 3'b000},
            {62'd0, d[0], e.rsp});
        chk($sformatf("dut%0d_event_cycle", d), 64'(cyc), 64'(e.at));
        if (!e.rsp) begin
          chk($sformatf("dut%0d_gnt", d), {61'd0, g}, 64'(1 << e.idx));
          chk($sformatf("dut%0d_mem_we_addr_wdata", d), {55'd0, we, a, wd},
              {55'd0, e.we, e.addr, e.wdata});
        end else begin
          chk($sformatf("dut%0d_rsp_valid", d), {61'd0, rv}, 64'(1 << e.idx));
          chk($sformatf("dut%0d_rsp_rdata", d), {60'd0, rd}, {60'd0, e.rdata});
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, gnt_a, rv_a, mwe_a, maddr_a, mwd_a, rdata_a);
    mon(1, gnt_b, rv_b, mwe_b, maddr_b, mwd_b, rdata_b);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_idle_a(input string nm);
    chk(nm, {42'd0, gnt_a, rv_a, rdata_a, mwe_a, maddr_a, mwd_a, busy_a}, 64'd0);
  endtask

  initial begin
    int c;
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    rst = 1'b1;
    tick(2);
    chk_idle_a("reset_outputs_a");
    chk("reset_outputs_b", {42'd0, gnt_b, rv_b, rdata_b, mwe_b, maddr_b, mwd_b, busy_b}, 64'd0);
    rst = 1'b0;

    // 1: write from requester 0
    c = cyc;
    req_a = 3'b001; we_a = 3'b001; addr_a[3:0] = 4'h3; wd_a[3:0] = 4'hA;
    exp_gnt(0, 0, 1'b1, 4'h3, 4'hA, c + 1);
    tick(1);
    req_a = '0;
    tick(1);
    chk("write_busy_low_s2", {63'd0, busy_a}, 64'd0);

    // 2: read by requester 1 of the address just written (rr_ptr=1)
    c = cyc;
    req_a = 3'b010; we_a = 3'b000; addr_a[7:4] = 4'h3; wd_a[7:4] = 4'h0;
    exp_gnt(0, 1, 1'b0, 4'h3, 4'h0, c + 1);
    exp_rsp(0, 1, 4'hA, c + 3);
    tick(1);
    req_a = '0;
    tick(3);
    chk("read_busy_low_after", {63'd0, busy_a}, 64'd0);

    // 3: reset restores rr_ptr=0, then all three write with req held
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    c = cyc;
    req_a = 3'b111; we_a = 3'b111;
    addr_a = {4'h4, 4'h2, 4'h1}; wd_a = {4'h7, 4'h6, 4'h5};
    exp_gnt(0, 0, 1'b1, 4'h1, 4'h5, c + 1);
    exp_gnt(0, 1, 1'b1, 4'h2, 4'h6, c + 3);
    exp_gnt(0, 2, 1'b1, 4'h4, 4'h7, c + 5);
    exp_gnt(0, 0, 1'b1, 4'h1, 4'h5, c + 7);
    tick(7);
    req_a = '0;
    tick(1);

    // 4: rr_ptr=1, req=101 -> 2 before 0
    c = cyc;
    req_a = 3'b101;
    exp_gnt(0, 2, 1'b1, 4'h4, 4'h7, c + 1);
    exp_gnt(0, 0, 1'b1, 4'h1, 4'h5, c + 3);
    tick(3);
    req_a = '0;
    tick(1);

    // 5: reset during WAIT of a read aborts it; rr_ptr back to 0
    c = cyc;
    req_a = 3'b010; we_a = 3'b000; addr_a[7:4] = 4'h3; wd_a[7:4] = 4'h0;
    exp_gnt(0, 1, 1'b0, 4'h3, 4'h0, c + 1);
    tick(1);
    req_a = '0;
    tick(1);
    chk("in_wait_busy_high", {63'd0, busy_a}, 64'd1);
    rst = 1'b1;
    tick(1);
    chk_idle_a("reset_in_wait_outputs");
    rst = 1'b0;
    req_a = 3'b011; we_a = 3'b011;
    addr_a[7:0] = {4'h9, 4'h8}; wd_a[7:0] = {4'h2, 4'h1};
    exp_gnt(0, 0, 1'b1, 4'h8, 4'h1, c + 4);
    exp_gnt(0, 1, 1'b1, 4'h9, 4'h2, c + 6);
    tick(3);
    req_a = '0;
    tick(4);

    // 6: READ_LAT=3 instance, read address 5 returning 7
    c = cyc;
    req_b = 3'b001; we_b = 3'b000; addr_b[3:0] = 4'h5; wd_b[3:0] = 4'h0;
    exp_gnt(1, 0, 1'b0, 4'h5, 4'h0, c + 1);
    exp_rsp(1, 0, 4'h7, c + 5);
    tick(1);
    req_b = '0;
    tick(2);
    chk("lat3_busy_in_wait", {63'd0, busy_b}, 64'd1);
    tick(4);
    chk("lat3_rsp_rdata_held", {60'd0, rdata_b}, 64'd7);
    chk("lat3_busy_low_after", {63'd0, busy_b}, 64'd0);

    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
